coherence_bus_ctrl: RTL and testbench

- Memory-side responder for the two snooping data caches. Arbitrates their dREN/dWEN requests onto a single RAM port.
- Drives the coherence snoop handshake (ccwait, ccinv, ccsnoopaddr) to the non-requesting cache.
- When the snooped cache holds the line dirty, forwards its write-back words directly to the requester while also updating RAM.
- Sits between the two dcache instances and the memory controller.

---
 rtl/coherence_bus_ctrl_pkg.sv | 20 ++
 rtl/coherence_bus_ctrl_if.sv | 32 +++
 rtl/coherence_bus_ctrl_arb.sv | 52 +++++
 rtl/coherence_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the coherence bus controller: FSM states, core count and core index.
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic core_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB    = 3'd1,
    SNOOP = 3'd2,
    FWD   = 3'd3,
    MEMLD = 3'd4
  } bus_state_t;

  function automatic core_idx_t other_core(input core_idx_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache/RAM-side bundle of the coherence bus; slave = bus controller, master = caches and RAM.
interface coherence_bus_ctrl_if #(
  parameter int WORD_W = 32
);
  logic [1:0]             dREN;
  logic [1:0]             dWEN;
  logic [1:0][WORD_W-1:0] daddr;
  logic [1:0][WORD_W-1:0] dstore;
  logic [1:0]             cctrans;
  logic [1:0]             ccwrite;
  logic [1:0]             dwait;
  logic [1:0][WORD_W-1:0] dload;
  logic [1:0]             ccwait;
  logic [1:0]             ccinv;
  logic [1:0][WORD_W-1:0] ccsnoopaddr;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic                   ramready;

  modport slave (
    input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramready,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramready,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl_arb.sv
// Two-input request arbiter. COHERENCE_RR_ARB_EN selects round-robin with a last-grant
// register; otherwise core 0 has fixed priority.
module bus_arbiter
  import cpu_types_pkg::*;
(
`ifdef COHERENCE_RR_ARB_EN
  input  logic            CLK,
  input  logic            nRST,
  input  logic            i_take,
`endif
  input  logic [CPUS-1:0] i_req,
  output core_idx_t       o_grant
);

`ifdef COHERENCE_RR_ARB_EN
  core_idx_t r_last;

  // Last-grant register; reset to core 1 so core 0 wins the first contest.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_grant;
    end else begin
      r_last <= r_last;
    end
  end

  // On contention favour the core not granted last.
  always_comb begin
    if (i_req == 2'b11) begin
      o_grant = other_core(r_last);
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end else begin
      o_grant = 1'b0;
    end
  end
`else
  // Fixed priority: core 0 always wins.
  always_comb begin
    if (i_req[0]) begin
      o_grant = 1'b0;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end else begin
      o_grant = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Memory-side responder for two snooping dcaches: arbitration, snoop handshake, write-back,
// cache-to-cache forwarding and RAM fills. Arbitration policy set by COHERENCE_RR_ARB_EN.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  coherence_bus_ctrl_if.slave  bus
);

  bus_state_t        r_state, w_state_nxt;
  core_idx_t         r_g, w_g_nxt;
  logic              r_wc, w_wc_nxt;
  core_idx_t         w_s;
  core_idx_t         w_arb_grant;
  logic [CPUS-1:0]   w_req;
  logic              w_done;
  logic              w_snoop_on;
  logic [WORD_W-1:0] w_req_addr;

  assign w_req      = bus.dREN | bus.dWEN;
  assign w_s        = other_core(r_g);
  assign w_req_addr = bus.daddr[r_g];

`ifdef COHERENCE_RR_ARB_EN
  logic w_arb_take;
  assign w_arb_take = (r_state == IDLE) && (|w_req);
  bus_arbiter u_arb (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_take  (w_arb_take),
    .i_req   (w_req),
    .o_grant (w_arb_grant)
  );
`else
  bus_arbiter u_arb (
    .i_req   (w_req),
    .o_grant (w_arb_grant)
  );
`endif

  // State, grant and word-count registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
      r_wc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_wc    <= w_wc_nxt;
    end
  end

  // Next-state and output mux; outputs are forced idle while nRST is low so a RAM
  // completion in the reset cycle is never acknowledged.
  always_comb begin
    w_state_nxt     = r_state;
    w_g_nxt         = r_g;
    w_wc_nxt        = r_wc;
    w_done          = 1'b0;
    w_snoop_on      = 1'b0;
    bus.dwait       = 2'b11;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    if (!nRST) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_wc_nxt = 1'b0;
          if (|w_req) begin
            w_g_nxt     = w_arb_grant;
            w_state_nxt = bus.dWEN[w_arb_grant] ? WB : SNOOP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WB: begin
          if (!w_req[r_g]) begin
            w_state_nxt = IDLE;
            w_wc_nxt    = 1'b0;
          end else begin
            bus.ramWEN     = 1'b1;
            bus.ramaddr    = w_req_addr;
            bus.ramstore   = bus.dstore[r_g];
            bus.dwait[r_g] = ~bus.ramready;
            w_done         = bus.ramready;
          end
        end
        SNOOP: begin
          w_snoop_on = 1'b1;
          if (bus.cctrans[w_s]) begin
            w_state_nxt = bus.ccwrite[w_s] ? FWD : MEMLD;
          end else begin
            w_state_nxt = SNOOP;
          end
        end
        FWD: begin
          // Dirty line: snooper's write-back goes to RAM and to the requester together.
          w_snoop_on     = 1'b1;
          bus.ramWEN     = bus.dWEN[w_s];
          bus.ramaddr    = bus.daddr[w_s];
          bus.ramstore   = bus.dstore[w_s];
          bus.dload[r_g] = bus.dstore[w_s];
          w_done         = bus.ramready & bus.dWEN[w_s] & bus.dREN[r_g];
          bus.dwait[r_g] = ~w_done;
          bus.dwait[w_s] = ~w_done;
        end
        MEMLD: begin
          w_snoop_on = 1'b1;
          if (!w_req[r_g]) begin
            w_state_nxt = IDLE;
            w_wc_nxt    = 1'b0;
          end else begin
            bus.ramREN     = 1'b1;
            bus.ramaddr    = w_req_addr;
            bus.dload[r_g] = bus.ramload;
            bus.dwait[r_g] = ~bus.ramready;
            w_done         = bus.ramready;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_wc_nxt    = 1'b0;
        end
      endcase

      if (w_done) begin
        if (r_wc) begin
          w_state_nxt = IDLE;
          w_wc_nxt    = 1'b0;
        end else begin
          w_wc_nxt = 1'b1;
        end
      end else begin
        w_wc_nxt = w_wc_nxt;
      end

      if (w_snoop_on) begin
        bus.ccwait[w_s]      = 1'b1;
        bus.ccsnoopaddr[w_s] = w_req_addr;
        bus.ccinv[w_s]       = bus.ccwrite[r_g];
      end else begin
        bus.ccwait = 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: caches and a zero-wait RAM are modelled here.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if #(.WORD_W(32)) bus();

  coherence_bus_ctrl #(.WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign bus.ramload = ram_fn(bus.ramaddr);

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          core;
    logic        has_data;
    logic [31:0] data;
  } ack_t;

  wr_t  wr_q[$];
  ack_t ack_q[$];
  logic no_snoop = 1'b0;

  always @(negedge CLK) begin : monitor
    wr_t  w;
    ack_t a;
    if (bus.ramWEN && bus.ramready) begin
      if (wr_q.size() == 0) begin
        check_eq("ram_wr_unexpected", 32'(wr_q.size()), 32'd1);
      end else begin
        w = wr_q.pop_front();
        check_eq("ram_wr_addr", bus.ramaddr, w.addr);
        check_eq("ram_wr_data", bus.ramstore, w.data);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!bus.dwait[i]) begin
        if (ack_q.size() == 0) begin
          check_eq("ack_unexpected", 32'(ack_q.size()), 32'd1);
        end else begin
          a = ack_q.pop_front();
          check_eq("ack_core", 32'(i), 32'(a.core));
          if (a.has_data) check_eq("dload", bus.dload[i], a.data);
          if (no_snoop) check_eq("wb_ccwait", 32'(bus.ccwait), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_all();
    bus.dREN     = 2'b00;
    bus.dWEN     = 2'b00;
    bus.cctrans  = 2'b00;
    bus.ccwrite  = 2'b00;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramready = 1'b1;
  endtask

  task automatic push_ack(input int core, input logic has_data, input logic [31:0] data);
    ack_t a;
    a.core = core;
    a.has_data = has_data;
    a.data = data;
    ack_q.push_back(a);
  endtask

  task automatic wait_ack(input int c);
    int n;
    logic seen;
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = !bus.dwait[c];
    end
    if (!seen) check_eq("ack_timeout", 32'(n), 32'd0);
    step();
  endtask

  task automatic wait_snoop(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      ok = |bus.ccwait;
    end
  endtask

  task automatic drain_check(input string tag);
    check_eq({tag, "_wr_q"}, 32'(wr_q.size()), 32'd0);
    check_eq({tag, "_ack_q"}, 32'(ack_q.size()), 32'd0);
  endtask

  // Requests must already be driven; the bench plays the snooped cache.
  task automatic snoop_read(input logic [31:0] base, input logic dirty, input logic rdx, output int gnt);
    logic ok;
    int g, s;
    logic [31:0] a, d;
    wr_t w;
    wait_snoop(ok);
    if (!ok) begin
      check_eq("snoop_timeout", 32'(ok), 32'd1);
      gnt = -1;
      clear_all();
      step();
      return;
    end
    s = bus.ccwait[1] ? 1 : 0;
    g = 1 - s;
    gnt = g;
    check_eq("ccwait_self", 32'(bus.ccwait[g]), 32'd0);
    check_eq("ccsnoopaddr", bus.ccsnoopaddr[s], base);
    check_eq("ccinv", 32'(bus.ccinv[s]), 32'(rdx));
    step();
    bus.cctrans[s] = 1'b1;
    bus.ccwrite[s] = dirty;
    for (int k = 0; k < 2; k++) begin
      a = base + 32'(4 * k);
      bus.daddr[g] = a;
      if (dirty) begin
        d = 32'hDEAD_0000 + 32'(4 * k);
        bus.dWEN[s]   = 1'b1;
        bus.daddr[s]  = a;
        bus.dstore[s] = d;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
        if (g == 0) begin
          push_ack(g, 1'b1, d);
          push_ack(s, 1'b0, 32'd0);
        end else begin
          push_ack(s, 1'b0, 32'd0);
          push_ack(g, 1'b1, d);
        end
      end else begin
        push_ack(g, 1'b1, ram_fn(a));
      end
      wait_ack(g);
    end
    clear_all();
    @(negedge CLK);
    check_eq("ccwait_drop", 32'(bus.ccwait), 32'd0);
    drain_check("read");
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] ev_data [2];
    logic [31:0] arb_exp [2];
    logic ok;
    int gnt;
    wr_t w;

    ev_data[0] = 32'hA5A5_A5A5;
    ev_data[1] = 32'h5A5A_5A5A;
    arb_exp[0] = 32'd0;
`ifdef COHERENCE_RR_ARB_EN
    arb_exp[1] = 32'd1;
`else
    arb_exp[1] = 32'd0;
`endif

    clear_all();
    nRST = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    check_eq("rst_dwait", 32'(bus.dwait), 32'd3);
    check_eq("rst_ram", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    check_eq("rst_ccwait", 32'(bus.ccwait), 32'd0);
    check_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
    step();
    nRST = 1'b1;
    step();
    @(negedge CLK);
    check_eq("post_rst_dwait", 32'(bus.dwait), 32'd3);
    step();

    // Core 1 eviction of a dirty line.
    no_snoop = 1'b1;
    bus.dWEN[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.daddr[1]  = 32'h100 + 32'(4 * k);
      bus.dstore[1] = ev_data[k];
      w.addr = bus.daddr[1];
      w.data = ev_data[k];
      wr_q.push_back(w);
      push_ack(1, 1'b0, 32'd0);
      wait_ack(1);
    end
    clear_all();
    no_snoop = 1'b0;
    @(negedge CLK);
    drain_check("evict");
    step();

    // Core 0 clean read.
    bus.dREN[0] = 1'b1;
    bus.daddr[0] = 32'h200;
    snoop_read(32'h200, 1'b0, 1'b0, gnt);
    check_eq("clean_grant", 32'(gnt), 32'd0);

    // Core 0 read-exclusive hitting a dirty line in core 1.
    bus.dREN[0] = 1'b1;
    bus.ccwrite[0] = 1'b1;
    bus.daddr[0] = 32'h300;
    snoop_read(32'h300, 1'b1, 1'b1, gnt);
    check_eq("rdx_grant", 32'(gnt), 32'd0);

    // Reset in MEMLD after the first word completes.
    bus.dREN[0] = 1'b1;
    bus.daddr[0] = 32'h400;
    wait_snoop(ok);
    check_eq("rst_mid_snoop", 32'(ok), 32'd1);
    step();
    bus.cctrans[1] = 1'b1;
    push_ack(0, 1'b1, ram_fn(32'h400));
    wait_ack(0);
    bus.daddr[0] = 32'h404;
    nRST = 1'b0;
    @(negedge CLK);
    check_eq("rst_cycle_dwait", 32'(bus.dwait), 32'd3);
    check_eq("rst_cycle_ramREN", 32'(bus.ramREN), 32'd0);
    step();
    nRST = 1'b1;
    clear_all();
    @(negedge CLK);
    check_eq("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
    check_eq("rst_mid_dwait", 32'(bus.dwait), 32'd3);
    check_eq("rst_mid_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("rst_mid_ccwait", 32'(bus.ccwait), 32'd0);
    drain_check("rst_mid");
    step();

    // Two simultaneous read contests.
    for (int r = 0; r < 2; r++) begin
      bus.dREN = 2'b11;
      bus.daddr[0] = 32'h500 + 32'(r * 64);
      bus.daddr[1] = 32'h500 + 32'(r * 64);
      snoop_read(32'h500 + 32'(r * 64), 1'b0, 1'b0, gnt);
      check_eq("arb_grant", 32'(gnt), arb_exp[r]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
